// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Holds the FSM state encoding, timeout default and wait-counter width.
package mem_ctrl_pkg;

  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the ACCESS state.
// Clear wins over enable; tc_o flags the last permitted wait cycle.
module mem_wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: stalls the pipeline across a
// registered memory request and flags bad or timed-out accesses.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        AccErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic        req_q, req_d;
  logic        tmo_q, tmo_d;
  logic [31:0] load_q, load_d;

  logic stall, err;
  logic clr, en, tc;
  logic any_req, bad_req;

  assign any_req = MemRead | MemWrite;
  assign bad_req = (MemRead & MemWrite) | (|Addr[1:0]);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .en_i  (en),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    req_d   = req_q;
    tmo_d   = tmo_q;
    load_d  = load_q;
    stall   = 1'b0;
    err     = 1'b0;
    clr     = 1'b1;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmo_d = 1'b0;
        if (any_req && bad_req) begin
          err = 1'b1;
        end else if (any_req) begin
          stall   = 1'b1;
          cmd_d   = '{we: MemWrite, addr: Addr, wdata: WData};
          req_d   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        clr   = 1'b0;
        if (mem_ready) begin
          clr     = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
          if (!cmd_q.we) begin
            load_d = mem_rdata;
          end
        end else if (tc) begin
          clr     = 1'b1;
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          en = 1'b1;
        end
      end
      DONE: begin
        err     = tmo_q;
        tmo_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      tmo_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      load_q  <= load_d;
    end
  end

  // Combinational outputs stay quiet while reset is held.
  assign Stall     = stall & rst_n;
  assign AccErr    = err & rst_n;
  assign mem_req   = req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign LoadData  = load_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (TIMEOUT=4).
// Expected access results go through a scoreboard queue.
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WData = '0;
  logic        Stall;
  logic [31:0] LoadData;
  logic        AccErr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    logic [31:0] load;
    logic        err;
    int          req_cyc;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total = 0;
  logic [31:0] model_load = '0;

  mem_access_ctrl #(
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WData     (WData),
    .Stall     (Stall),
    .LoadData  (LoadData),
    .AccErr    (AccErr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    MemRead = 1'b1;
    Addr = 32'h10;
    #1;
    total++;
    if (Stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", Stall);
    else passed++;
    total++;
    if (AccErr !== 1'b0) $display("FAIL rst_err: got %b want 0", AccErr);
    else passed++;
    total++;
    if (mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req);
    else passed++;
    total++;
    if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we);
    else passed++;
    total++;
    if (mem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", mem_addr);
    else passed++;
    total++;
    if (mem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", mem_wdata);
    else passed++;
    total++;
    if (LoadData !== 32'h0) $display("FAIL rst_load: got %h want 0", LoadData);
    else passed++;
    MemRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_access(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdata, input int wait_n,
                           input string nm);
    exp_t e;
    int   n;
    bit   tmo;
    tmo = (wait_n >= TMO);
    e.load = (rd && !tmo) ? rdata : model_load;
    e.err = tmo;
    e.req_cyc = tmo ? TMO : wait_n + 1;
    model_load = e.load;
    sb.push_back(e);
    MemRead = rd;
    MemWrite = wr;
    Addr = a;
    WData = wd;
    mem_ready = 1'b0;
    #1;
    total++;
    if (Stall !== 1'b1) $display("FAIL %s acc_stall: got %b want 1", nm, Stall);
    else passed++;
    total++;
    if (AccErr !== 1'b0) $display("FAIL %s acc_err: got %b want 0", nm, AccErr);
    else passed++;
    tick();
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      mem_ready = (n == wait_n);
      mem_rdata = (n == wait_n) ? rdata : 32'hDEAD_BEEF;
      #1;
      total++;
      if (Stall !== 1'b1 || mem_we !== wr)
        $display("FAIL %s wait_ctl: got stall=%b we=%b want 1/%b", nm, Stall, mem_we, wr);
      else passed++;
      total++;
      if (mem_addr !== a || mem_wdata !== wd)
        $display("FAIL %s wait_bus: got %h/%h want %h/%h", nm, mem_addr, mem_wdata, a, wd);
      else passed++;
      tick();
      n++;
    end
    mem_ready = 1'b0;
    #1;
    e = sb.pop_front();
    total++;
    if (n !== e.req_cyc) $display("FAIL %s req_cycles: got %0d want %0d", nm, n, e.req_cyc);
    else passed++;
    total++;
    if (Stall !== 1'b0) $display("FAIL %s done_stall: got %b want 0", nm, Stall);
    else passed++;
    total++;
    if (LoadData !== e.load) $display("FAIL %s load: got %h want %h", nm, LoadData, e.load);
    else passed++;
    total++;
    if (AccErr !== e.err) $display("FAIL %s done_err: got %b want %b", nm, AccErr, e.err);
    else passed++;
    tick();
    MemRead = 1'b0;
    MemWrite = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || Stall !== 1'b0 || AccErr !== 1'b0)
      $display("FAIL %s idle: got req=%b stall=%b err=%b want 0/0/0", nm, mem_req, Stall, AccErr);
    else passed++;
  endtask

  task automatic test_bad(input logic rd, input logic wr,
                          input logic [31:0] a, input string nm);
    MemRead = rd;
    MemWrite = wr;
    Addr = a;
    #1;
    total++;
    if (AccErr !== 1'b1) $display("FAIL %s err: got %b want 1", nm, AccErr);
    else passed++;
    total++;
    if (Stall !== 1'b0) $display("FAIL %s stall: got %b want 0", nm, Stall);
    else passed++;
    tick();
    MemRead = 1'b0;
    MemWrite = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || AccErr !== 1'b0)
      $display("FAIL %s after: got req=%b err=%b want 0/0", nm, mem_req, AccErr);
    else passed++;
  endtask

  task automatic test_read;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 0, "read");
  endtask

  task automatic test_write_wait;
    do_access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0, 2, "write");
  endtask

  task automatic test_misaligned;
    test_bad(1'b1, 1'b0, 32'h13, "misal_rd");
    test_bad(1'b0, 1'b1, 32'h22, "misal_wr");
  endtask

  task automatic test_conflict;
    test_bad(1'b1, 1'b1, 32'h40, "conflict");
  endtask

  task automatic test_timeout;
    do_access(1'b1, 1'b0, 32'h30, 32'h0, 32'h0BAD_0BAD, 99, "timeout");
  endtask

  task automatic test_back_to_back;
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 32'hA5A5_0001, 0, "b2b_rd0");
    do_access(1'b1, 1'b0, 32'h48, 32'h0, 32'h5A5A_0002, TMO - 1, "b2b_rd1");
    do_access(1'b0, 1'b1, 32'h4C, 32'h0F0F_0F0F, 32'h0, 1, "b2b_wr");
  endtask

  task automatic test_ready_idle;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    #1;
    tick();
    total++;
    if (mem_req !== 1'b0 || Stall !== 1'b0)
      $display("FAIL rdy_idle ctl: got req=%b stall=%b want 0/0", mem_req, Stall);
    else passed++;
    total++;
    if (LoadData !== model_load)
      $display("FAIL rdy_idle load: got %h want %h", LoadData, model_load);
    else passed++;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    MemRead = 1'b1;
    Addr = 32'h80;
    mem_ready = 1'b0;
    #1;
    tick();
    tick();
    total++;
    if (mem_req !== 1'b1) $display("FAIL mid_pre req: got %b want 1", mem_req);
    else passed++;
    rst_n = 1'b0;
    #1;
    model_load = '0;
    total++;
    if (Stall !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL mid_rst ctl: got stall=%b req=%b want 0/0", Stall, mem_req);
    else passed++;
    total++;
    if (LoadData !== 32'h0 || mem_addr !== 32'h0)
      $display("FAIL mid_rst data: got %h/%h want 0/0", LoadData, mem_addr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80)
      $display("FAIL mid_first: got req=%b addr=%h want 1/00000080", mem_req, mem_addr);
    else passed++;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_55AA;
    tick();
    model_load = 32'h0000_55AA;
    mem_ready = 1'b0;
    total++;
    if (LoadData !== model_load || Stall !== 1'b0)
      $display("FAIL mid_done: got %h stall=%b want %h/0", LoadData, Stall, model_load);
    else passed++;
    MemRead = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_misaligned();
    test_conflict();
    test_timeout();
    test_back_to_back();
    test_ready_idle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max ACCESS cycles waiting for mem_ready (legal 1..15).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 MemRead  input  1  EXE/MEM-stage load request.
REQ-005 MemWrite  input  1  EXE/MEM-stage store request.
REQ-006 Addr  input  32  EXE/MEM-stage result, byte address.
REQ-007 WData  input  32  EXE/MEM-stage Rt value, store data.
REQ-008 Stall  output  1  freeze PC, IF/ID, ID/EXE and EXE/MEM registers.
REQ-009 LoadData  output  32  registered load result for the MEM/WB register.
REQ-010 AccErr  output  1  one-cycle pulse: misaligned, conflicting or timed-out access.
REQ-011 mem_req  output  1  registered request to data memory.
REQ-012 mem_we  output  1  registered write enable, valid with mem_req.
REQ-013 mem_addr  output  32  registered word address, valid with mem_req.
REQ-014 mem_wdata  output  32  registered store data, valid with mem_req.
REQ-015 mem_ready  input  1  memory completion, sampled only in ACCESS.
REQ-016 mem_rdata  input  32  read data, valid when mem_ready=1.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE.
REQ-018 IDLE, valid access (exactly one of MemRead/MemWrite, Addr[1:0]=00): Stall=1 combinationally; next edge latch Addr/WData/MemWrite into mem_addr/mem_wdata/mem_we, set mem_req=1, go ACCESS.
REQ-019 ACCESS: Stall=1, mem_req=1; mem_addr/mem_we/mem_wdata held stable.
REQ-020 ACCESS, mem_ready=1: on that edge, mem_req->0, LoadData<=mem_rdata if read (unchanged if write), wait counter->0, go DONE.
REQ-021 ACCESS, mem_ready=0: wait counter increments; when counter reaches TIMEOUT-1 (i.e. TIMEOUT ACCESS cycles without ready): mem_req->0, LoadData unchanged, AccErr=1 in the following DONE cycle, go DONE.
REQ-022 DONE: Stall=0 for exactly one cycle so pipeline advances; unconditionally go IDLE; MemRead/MemWrite ignored in DONE.
REQ-023 Minimum latency: valid access with mem_ready in first ACCESS cycle -> Stall high 2 cycles, low in DONE (3-cycle instruction slot).
REQ-024 IDLE, Addr[1:0]!=00 with MemRead or MemWrite: AccErr=1 that cycle, no Stall, no mem_req, stay IDLE.
REQ-025 IDLE, MemRead=1 and MemWrite=1: AccErr=1 that cycle, no Stall, no mem_req, stay IDLE.
REQ-026 IDLE, neither MemRead nor MemWrite: Stall=0, AccErr=0, stay IDLE.
REQ-027 mem_ready in IDLE or DONE ignored; no state or output change.
REQ-028 AccErr never high for a successful access; at most one pulse per instruction.

Reset
REQ-029 rst_n=0 at any time, including mid-ACCESS: state IDLE, Stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, LoadData=0, AccErr=0, wait counter=0.
REQ-030 First valid access is accepted on the first posedge after rst_n deasserts.

Structure
REQ-031 Shared package mem_ctrl_pkg holds the state enumeration, TIMEOUT default and counter width (4).
REQ-032 One sub-module, mem_wait_timer: 4-bit counter with clear/enable and terminal-count output.

Verification
REQ-033 Read: MemRead=1, Addr=0x0000_0010, mem_ready=1 first ACCESS cycle, mem_rdata=0x1234_5678 -> mem_req 1 cycle, Stall 2 cycles, LoadData=0x1234_5678 in DONE.
REQ-034 Write with wait: MemWrite=1, Addr=0x20, WData=0xCAFE_F00D, mem_ready after 3 cycles -> mem_we=1, mem_addr/mem_wdata stable 3 cycles, LoadData unchanged.
REQ-035 Misaligned: MemRead=1, Addr=0x0000_0013 -> AccErr pulse 1 cycle, Stall=0, mem_req=0.
REQ-036 Timeout: TIMEOUT=4, mem_ready held 0 -> mem_req high exactly 4 cycles, AccErr pulse in DONE, back to IDLE.
REQ-037 Reset mid-op: rst_n=0 during second ACCESS cycle -> Stall, mem_req, LoadData immediately 0; state IDLE.
REQ-038 Conflict: MemRead=MemWrite=1, Addr=0x40 -> AccErr pulse, no request, no stall.
